// File: rtl/conv_ctrl_pkg.sv
// Shared encodings for the conv-layer APB sequencer: states, steps, register map, error codes.
package conv_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_GAP,
      ST_FIN,
      ST_FAIL
   } state_t;

   typedef enum logic [1:0] {
      STEP_CFG0 = 2'd0,
      STEP_CFG1 = 2'd1,
      STEP_CMD  = 2'd2,
      STEP_STAT = 2'd3
   } step_t;

   localparam logic [31:0] ADDR_COMMAND = 32'h0000_0000;
   localparam logic [31:0] ADDR_STATUS  = 32'h0000_0004;
   localparam logic [31:0] ADDR_CONFIG0 = 32'h0000_0008;
   localparam logic [31:0] ADDR_CONFIG1 = 32'h0000_000C;

   localparam logic [31:0] CMD_START = 32'h0000_0001;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_PSLVERR = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   function automatic logic [31:0] step_addr(step_t s);
      case (s)
         STEP_CFG0: step_addr = ADDR_CONFIG0;
         STEP_CFG1: step_addr = ADDR_CONFIG1;
         STEP_CMD:  step_addr = ADDR_COMMAND;
         default:   step_addr = ADDR_STATUS;
      endcase
   endfunction

endpackage

// File: rtl/conv_ctrl_seq_apb_xfer.sv
// Single APB master transfer: go loads SETUP, ACCESS follows, complete fires on PREADY.
module apb_xfer (
   input  logic        clk,
   input  logic        resetn,
   input  logic        go,
   input  logic [31:0] addr,
   input  logic        write,
   input  logic [31:0] wdata,
   input  logic        pready,
   output logic        psel,
   output logic        penable,
   output logic [31:0] paddr,
   output logic        pwrite,
   output logic [31:0] pwdata,
   output logic        complete
);

   assign complete = psel & penable & pready;

   // A go on the completion cycle starts the next SETUP directly (back-to-back).
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         psel    <= 1'b0;
         penable <= 1'b0;
         paddr   <= '0;
         pwrite  <= 1'b0;
         pwdata  <= '0;
      end else if (go) begin
         psel    <= 1'b1;
         penable <= 1'b0;
         paddr   <= addr;
         pwrite  <= write;
         pwdata  <= write ? wdata : 32'h0;
      end else if (psel && !penable) begin
         penable <= 1'b1;
      end else if (complete) begin
         psel    <= 1'b0;
         penable <= 1'b0;
      end
   end

endmodule

// File: rtl/conv_ctrl_seq.sv
// Runs one conv layer over APB: write CONFIG0/1, write COMMAND, poll STATUS until done or timeout.
module conv_ctrl_seq
   import conv_ctrl_pkg::*;
#(
   parameter int POLL_GAP    = 16,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [31:0] cfg0,
   input  logic [31:0] cfg1,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [31:0] status_q,
   output logic [31:0] paddr,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [31:0] pwdata,
   input  logic [31:0] prdata,
   input  logic        pready,
   input  logic        pslverr
);

   localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);
   localparam logic [31:0] TMO_LIM = 32'(TIMEOUT_CYC);

   state_t           state_reg;
   step_t            step_reg;
   step_t            go_step;
   logic [31:0]      cfg0_reg;
   logic [31:0]      cfg1_reg;
   logic [GAP_W-1:0] gap_cnt_reg;
   logic [31:0]      tmo_cnt_reg;
   logic             tmo_run_reg;
   logic             xfer_go;
   logic [31:0]      xfer_wdata;
   logic             complete;
   logic             tmo_hit;
   logic             gap_end;

   assign tmo_hit = (tmo_cnt_reg >= TMO_LIM);
   assign gap_end = (gap_cnt_reg == GAP_LAST);

   always_comb begin
      xfer_go = 1'b0;
      go_step = step_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               xfer_go = 1'b1;
               go_step = STEP_CFG0;
            end
         end
         ST_ACCESS: begin
            if (complete && !pslverr && (step_reg == STEP_CFG0 || step_reg == STEP_CFG1)) begin
               xfer_go = 1'b1;
               go_step = step_t'(step_reg + 2'd1);
            end
         end
         ST_GAP: begin
            if (!tmo_hit && gap_end) begin
               xfer_go = 1'b1;
               go_step = STEP_STAT;
            end
         end
         default: ;
      endcase
   end

   // CONFIG0 goes out in the same cycle START is accepted, before cfg0_reg is loaded.
   always_comb begin
      xfer_wdata = 32'h0;
      case (go_step)
         STEP_CFG0: xfer_wdata = (state_reg == ST_IDLE) ? cfg0 : cfg0_reg;
         STEP_CFG1: xfer_wdata = cfg1_reg;
         STEP_CMD:  xfer_wdata = CMD_START;
         default:   xfer_wdata = 32'h0;
      endcase
   end

   apb_xfer u_xfer (
      .clk      (clk),
      .resetn   (resetn),
      .go       (xfer_go),
      .addr     (step_addr(go_step)),
      .write    (go_step != STEP_STAT),
      .wdata    (xfer_wdata),
      .pready   (pready),
      .psel     (psel),
      .penable  (penable),
      .paddr    (paddr),
      .pwrite   (pwrite),
      .pwdata   (pwdata),
      .complete (complete)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg   <= ST_IDLE;
         step_reg    <= STEP_CFG0;
         cfg0_reg    <= '0;
         cfg1_reg    <= '0;
         gap_cnt_reg <= '0;
         tmo_cnt_reg <= '0;
         tmo_run_reg <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         err_code    <= ERR_NONE;
         status_q    <= '0;
      end else begin
         if (xfer_go) step_reg <= go_step;
         if (tmo_run_reg && tmo_cnt_reg != 32'hFFFF_FFFF) tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  cfg0_reg  <= cfg0;
                  cfg1_reg  <= cfg1;
                  error     <= 1'b0;
                  err_code  <= ERR_NONE;
                  busy      <= 1'b1;
                  state_reg <= ST_SETUP;
               end
            end
            ST_SETUP: state_reg <= ST_ACCESS;
            ST_ACCESS: begin
               if (complete) begin
                  if (pslverr) begin
                     error     <= 1'b1;
                     err_code  <= ERR_PSLVERR;
                     busy      <= 1'b0;
                     state_reg <= ST_FAIL;
                  end else begin
                     case (step_reg)
                        STEP_CFG0, STEP_CFG1: state_reg <= ST_SETUP;
                        STEP_CMD: begin
                           tmo_cnt_reg <= '0;
                           tmo_run_reg <= 1'b1;
                           gap_cnt_reg <= '0;
                           state_reg   <= ST_GAP;
                        end
                        default: begin
                           status_q <= prdata;
                           if (prdata[0]) begin
                              done      <= 1'b1;
                              busy      <= 1'b0;
                              state_reg <= ST_FIN;
                           end else begin
                              gap_cnt_reg <= '0;
                              state_reg   <= ST_GAP;
                           end
                        end
                     endcase
                  end
               end
            end
            ST_GAP: begin
               if (tmo_hit) begin
                  error     <= 1'b1;
                  err_code  <= ERR_TIMEOUT;
                  busy      <= 1'b0;
                  state_reg <= ST_FAIL;
               end else if (gap_end) begin
                  state_reg <= ST_SETUP;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg + 1'b1;
               end
            end
            ST_FIN: begin
               done        <= 1'b0;
               tmo_run_reg <= 1'b0;
               state_reg   <= ST_IDLE;
            end
            ST_FAIL: begin
               tmo_run_reg <= 1'b0;
               state_reg   <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_ctrl_seq.sv
// Scoreboarded bench for conv_ctrl_seq with a scripted APB completer.
module tb_conv_ctrl_seq;

   localparam int POLL_GAP    = 16;
   localparam int TIMEOUT_CYC = 100;
   localparam int LAT         = 6 + POLL_GAP + 2;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [31:0] cfg0 = '0;
   logic [31:0] cfg1 = '0;
   logic        busy, done, error;
   logic [1:0]  err_code;
   logic [31:0] status_q, paddr, pwdata;
   logic        psel, penable, pwrite;
   logic [31:0] prdata = '0;
   logic        pready = 1'b0;
   logic        pslverr = 1'b0;

   conv_ctrl_seq #(.POLL_GAP(POLL_GAP), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk(clk), .resetn(resetn), .start(start), .cfg0(cfg0), .cfg1(cfg1),
      .busy(busy), .done(done), .error(error), .err_code(err_code), .status_q(status_q),
      .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [31:0] data;
      int          cyc;
   } xfer_t;

   xfer_t       exp_q[$];
   xfer_t       obs_q[$];
   xfer_t       mon_x;
   logic [31:0] stat_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc_cnt = 0;
   int          done_cnt = 0;
   int          wait_left = 0;
   int          wait_n = 0;
   logic [31:0] wait_addr = 32'hFFFF_FFFF;
   logic [31:0] err_addr = 32'hFFFF_FFFF;

   // Completed transfers are captured on the edge they complete.
   always @(posedge clk) begin
      cyc_cnt = cyc_cnt + 1;
      if (resetn && psel && penable && pready) begin
         mon_x.addr  = paddr;
         mon_x.write = pwrite;
         mon_x.data  = pwdata;
         mon_x.cyc   = cyc_cnt;
         obs_q.push_back(mon_x);
      end
   end

   // Completer: optional wait states per address, optional PSLVERR, scripted STATUS values.
   always @(negedge clk) begin
      if (done) done_cnt = done_cnt + 1;
      if (!resetn || !psel) begin
         pready = 1'b0; pslverr = 1'b0; prdata = '0; wait_left = 0;
      end else if (!penable) begin
         wait_left = (paddr == wait_addr) ? wait_n : 0;
         pready = 1'b0; pslverr = 1'b0;
      end else if (wait_left > 0) begin
         wait_left = wait_left - 1;
         pready = 1'b0;
      end else begin
         pready  = 1'b1;
         pslverr = (paddr == err_addr);
         if (pwrite) prdata = '0;
         else prdata = (stat_q.size() > 0) ? stat_q.pop_front() : 32'h0;
      end
   end

   task automatic push_exp(input logic [31:0] a, input logic w, input logic [31:0] d);
      xfer_t x;
      x.addr = a; x.write = w; x.data = d; x.cyc = 0;
      exp_q.push_back(x);
   endtask

   task automatic kick(input logic [31:0] c0, input logic [31:0] c1, output int t0);
      @(negedge clk);
      cfg0 = c0; cfg1 = c1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      t0 = cyc_cnt;
   endtask

   task automatic wait_end(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (done || error) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({psel, penable, pwrite} !== 3'b000) begin n_err++; $display("FAIL reset_apb_ctl got %b want 000", {psel, penable, pwrite}); end
      n_cmp++;
      if ({busy, done, error, err_code} !== 5'b0) begin n_err++; $display("FAIL reset_flags got %b want 00000", {busy, done, error, err_code}); end
      n_cmp++;
      if ({paddr, pwdata, status_q} !== 96'h0) begin n_err++; $display("FAIL reset_data got %h want 0", {paddr, pwdata, status_q}); end
      resetn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      int t0, dc; bit ok; xfer_t e, o;
      push_exp(32'h08, 1'b1, 32'h001C001C);
      push_exp(32'h0C, 1'b1, 32'h00030010);
      push_exp(32'h00, 1'b1, 32'h1);
      push_exp(32'h04, 1'b0, 32'h0);
      stat_q.push_back(32'h1);
      dc = done_cnt;
      kick(32'h001C001C, 32'h00030010, t0);
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy got %b want 1", busy); end
      wait_end(200, ok);
      n_cmp++;
      if (!ok || done !== 1'b1) begin n_err++; $display("FAIL single_done got done=%b ok=%0d want done=1", done, ok); end
      n_cmp++;
      if (cyc_cnt - t0 !== LAT) begin n_err++; $display("FAIL single_latency got %0d want %0d", cyc_cnt - t0, LAT); end
      n_cmp++;
      if (busy !== 1'b0 || status_q !== 32'h1) begin n_err++; $display("FAIL single_end got busy=%b status=%h want 0/1", busy, status_q); end
      start = 1'b1;  // START during the FIN cycle must be ignored
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_fin_start got done=%b busy=%b want 0/0", done, busy); end
      repeat (4) @(negedge clk);
      n_cmp++;
      if (done_cnt - dc !== 1) begin n_err++; $display("FAIL single_done_count got %0d want 1", done_cnt - dc); end
      n_cmp++;
      if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL single_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o.addr !== e.addr || o.write !== e.write || o.data !== e.data) begin
            n_err++; $display("FAIL single_xfer got a=%h w=%b d=%h want a=%h w=%b d=%h", o.addr, o.write, o.data, e.addr, e.write, e.data);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_poll();
      int t0, dc, prev; bit ok; xfer_t e, o;
      push_exp(32'h08, 1'b1, 32'hA5A5_0001);
      push_exp(32'h0C, 1'b1, 32'h5A5A_0002);
      push_exp(32'h00, 1'b1, 32'h1);
      for (int i = 0; i < 4; i++) push_exp(32'h04, 1'b0, 32'h0);
      stat_q.push_back(32'h0); stat_q.push_back(32'h0); stat_q.push_back(32'h0); stat_q.push_back(32'h1);
      dc = done_cnt;
      kick(32'hA5A5_0001, 32'h5A5A_0002, t0);
      wait_end(300, ok);
      n_cmp++;
      if (!ok || done !== 1'b1) begin n_err++; $display("FAIL poll_done got done=%b ok=%0d want done=1", done, ok); end
      n_cmp++;
      if (cyc_cnt - t0 !== LAT + 3 * (POLL_GAP + 2)) begin n_err++; $display("FAIL poll_latency got %0d want %0d", cyc_cnt - t0, LAT + 3 * (POLL_GAP + 2)); end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (status_q !== 32'h1 || done_cnt - dc !== 1) begin n_err++; $display("FAIL poll_end got status=%h dones=%0d want 1/1", status_q, done_cnt - dc); end
      n_cmp++;
      if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL poll_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      prev = -1;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o.addr !== e.addr || o.write !== e.write || o.data !== e.data) begin
            n_err++; $display("FAIL poll_xfer got a=%h w=%b d=%h want a=%h w=%b d=%h", o.addr, o.write, o.data, e.addr, e.write, e.data);
         end
         if (!o.write) begin
            if (prev >= 0) begin
               n_cmp++;
               if (o.cyc - prev !== POLL_GAP + 2) begin n_err++; $display("FAIL poll_spacing got %0d want %0d", o.cyc - prev, POLL_GAP + 2); end
            end
            prev = o.cyc;
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_wait_state();
      int t0; bit ok, found; xfer_t e, o;
      wait_addr = 32'h0C; wait_n = 5;
      push_exp(32'h08, 1'b1, 32'h1111_2222);
      push_exp(32'h0C, 1'b1, 32'h3333_4444);
      push_exp(32'h00, 1'b1, 32'h1);
      push_exp(32'h04, 1'b0, 32'h0);
      stat_q.push_back(32'h1);
      kick(32'h1111_2222, 32'h3333_4444, t0);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (psel && penable && paddr == 32'h0C) begin found = 1'b1; break; end
      end
      n_cmp++;
      if (!found) begin n_err++; $display("FAIL wait_access got none want ACCESS to 0C"); end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if ({psel, penable, pwrite} !== 3'b111 || paddr !== 32'h0C || pwdata !== 32'h3333_4444) begin
            n_err++; $display("FAIL wait_stable got ctl=%b a=%h d=%h want 111/0C/33334444", {psel, penable, pwrite}, paddr, pwdata);
         end
         @(negedge clk);
      end
      wait_end(200, ok);
      n_cmp++;
      if (!ok || done !== 1'b1 || cyc_cnt - t0 !== LAT + 5) begin n_err++; $display("FAIL wait_latency got %0d done=%b want %0d", cyc_cnt - t0, done, LAT + 5); end
      repeat (2) @(negedge clk);
      n_cmp++;
      if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL wait_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o.addr !== e.addr || o.write !== e.write || o.data !== e.data) begin
            n_err++; $display("FAIL wait_xfer got a=%h w=%b d=%h want a=%h w=%b d=%h", o.addr, o.write, o.data, e.addr, e.write, e.data);
         end
      end
      exp_q.delete(); obs_q.delete();
      wait_addr = 32'hFFFF_FFFF; wait_n = 0;
   endtask

   task automatic test_slverr();
      int t0, dc; bit ok; xfer_t e, o;
      err_addr = 32'h00;
      push_exp(32'h08, 1'b1, 32'h0000_00F0);
      push_exp(32'h0C, 1'b1, 32'h0000_000F);
      push_exp(32'h00, 1'b1, 32'h1);
      dc = done_cnt;
      kick(32'h0000_00F0, 32'h0000_000F, t0);
      wait_end(100, ok);
      n_cmp++;
      if (!ok || error !== 1'b1 || err_code !== 2'b01) begin n_err++; $display("FAIL slverr_flag got err=%b code=%b want 1/01", error, err_code); end
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL slverr_busy got busy=%b done=%b want 0/0", busy, done); end
      repeat (POLL_GAP + 6) @(negedge clk);
      n_cmp++;
      if (error !== 1'b1 || err_code !== 2'b01 || done_cnt !== dc) begin n_err++; $display("FAIL slverr_sticky got err=%b code=%b dones=%0d want 1/01/0", error, err_code, done_cnt - dc); end
      n_cmp++;
      if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL slverr_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o.addr !== e.addr || o.write !== e.write || o.data !== e.data) begin
            n_err++; $display("FAIL slverr_xfer got a=%h w=%b d=%h want a=%h w=%b d=%h", o.addr, o.write, o.data, e.addr, e.write, e.data);
         end
      end
      exp_q.delete(); obs_q.delete();
      err_addr = 32'hFFFF_FFFF;
      stat_q.push_back(32'h1);
      kick(32'h0000_0001, 32'h0000_0002, t0);
      n_cmp++;
      if (error !== 1'b0 || err_code !== 2'b00 || busy !== 1'b1) begin n_err++; $display("FAIL slverr_clear got err=%b code=%b busy=%b want 0/00/1", error, err_code, busy); end
      wait_end(200, ok);
      n_cmp++;
      if (!ok || done !== 1'b1 || error !== 1'b0) begin n_err++; $display("FAIL slverr_rerun got done=%b err=%b want 1/0", done, error); end
      repeat (2) @(negedge clk);
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_timeout();
      int t0, dc, n_cfg0, n_wr; bit ok;
      dc = done_cnt;
      kick(32'hDEAD_0001, 32'hBEEF_0002, t0);
      for (int k = 0; k < 3; k++) begin
         repeat (9) @(negedge clk);
         cfg0 = 32'h0BAD_0BAD; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      wait_end(400, ok);
      n_cmp++;
      if (!ok || error !== 1'b1 || err_code !== 2'b10) begin n_err++; $display("FAIL timeout_flag got err=%b code=%b want 1/10", error, err_code); end
      start = 1'b1;  // START during the FAIL cycle must be ignored
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || error !== 1'b1 || psel !== 1'b0) begin n_err++; $display("FAIL timeout_fail_start got busy=%b err=%b psel=%b want 0/1/0", busy, error, psel); end
      n_cmp++;
      if (done_cnt !== dc) begin n_err++; $display("FAIL timeout_no_done got %0d want 0", done_cnt - dc); end
      n_cfg0 = 0; n_wr = 0;
      foreach (obs_q[i]) begin
         if (obs_q[i].write) n_wr++;
         if (obs_q[i].addr == 32'h08) n_cfg0++;
      end
      n_cmp++;
      if (n_cfg0 !== 1 || n_wr !== 3) begin n_err++; $display("FAIL timeout_restart got cfg0_writes=%0d writes=%0d want 1/3", n_cfg0, n_wr); end
      n_cmp++;
      if (obs_q.size() < 4) begin n_err++; $display("FAIL timeout_polls got %0d transfers want >=4", obs_q.size()); end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_mid();
      int t0, dc; bit found;
      wait_addr = 32'h0C; wait_n = 20;
      stat_q.push_back(32'h1);
      dc = done_cnt;
      kick(32'h1234_5678, 32'h9ABC_DEF0, t0);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (psel && penable && paddr == 32'h0C) begin found = 1'b1; break; end
      end
      n_cmp++;
      if (!found) begin n_err++; $display("FAIL rstmid_access got none want ACCESS to 0C"); end
      resetn = 1'b0;
      #1;
      n_cmp++;
      if ({psel, penable, busy} !== 3'b000) begin n_err++; $display("FAIL rstmid_immediate got psel/penable/busy=%b want 000", {psel, penable, busy}); end
      @(negedge clk);
      resetn = 1'b1;
      repeat (60) @(negedge clk);
      n_cmp++;
      if (done_cnt !== dc || error !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_after got dones=%0d err=%b busy=%b want 0/0/0", done_cnt - dc, error, busy); end
      n_cmp++;
      if (obs_q.size() !== 1) begin n_err++; $display("FAIL rstmid_xfers got %0d want 1", obs_q.size()); end
      exp_q.delete(); obs_q.delete(); stat_q.delete();
      wait_addr = 32'hFFFF_FFFF; wait_n = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_poll();
      test_wait_state();
      test_slverr();
      test_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
